// File: rtl/membus_arb2_pkg.sv
// Shared types and encodings for the two-master memory-bus arbiter.
package membus_arb2_pkg;

    localparam int unsigned MA_W = 18;
    localparam int unsigned MB_W = 36;

    // Addresses keep the machine's bit numbering [18:35]; data words are [0:35].
    typedef logic [18:18+MA_W-1] ma_t;
    typedef logic [0:MB_W-1]     mb_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/membus_arb2_nxm_timer.sv
// Address-acknowledge watchdog: counts ADDR clocks, flags the last allowed one.
module membus_arb2_nxm_timer #(
    parameter int unsigned LIMIT = 64,
    parameter int unsigned W     = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over count.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_c = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/membus_arb2.sv
// Two-master arbiter sharing one memory-bus port, one full memory cycle per grant.
module membus_arb2 import membus_arb2_pkg::*; #(
    parameter int unsigned FIXED_PRIO  = 0,
    parameter int unsigned NXM_TIMEOUT = 64,
    parameter int unsigned TW          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic m0_rq_cyc,
    input  logic m0_rd_rq,
    input  logic m0_wr_rq,
    input  ma_t  m0_ma,
    input  logic m0_fmc_select,
    input  mb_t  m0_mb_out,
    input  logic m0_wr_rs,
    output logic m0_addr_ack,
    output logic m0_rd_rs,
    output mb_t  m0_mb_in,
    output logic m0_nxm,
    input  logic m1_rq_cyc,
    input  logic m1_rd_rq,
    input  logic m1_wr_rq,
    input  ma_t  m1_ma,
    input  logic m1_fmc_select,
    input  mb_t  m1_mb_out,
    input  logic m1_wr_rs,
    output logic m1_addr_ack,
    output logic m1_rd_rs,
    output mb_t  m1_mb_in,
    output logic m1_nxm,
    output logic mem_rq_cyc,
    output logic mem_rd_rq,
    output logic mem_wr_rq,
    output logic mem_fmc_select,
    output ma_t  mem_ma,
    output mb_t  mem_mb_out,
    output logic mem_wr_rs,
    input  logic mem_addr_ack,
    input  logic mem_rd_rs,
    input  mb_t  mem_mb_in
);

    logic [1:0] state_q, state_d;
    logic       g_q, g_d;
    logic       last_q, last_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       pick;
    logic       nxm_c;
    logic       timer_en;
    logic       timer_clr;
    logic       timer_exp_c;
    logic       live;

    logic sel_rq_cyc, sel_rd_rq, sel_wr_rq, sel_fmc, sel_wr_rs;
    ma_t  sel_ma;
    mb_t  sel_mb;

    // Granted master's request lines.
    always_comb begin
        sel_rq_cyc = g_q ? m1_rq_cyc     : m0_rq_cyc;
        sel_rd_rq  = g_q ? m1_rd_rq      : m0_rd_rq;
        sel_wr_rq  = g_q ? m1_wr_rq      : m0_wr_rq;
        sel_fmc    = g_q ? m1_fmc_select : m0_fmc_select;
        sel_wr_rs  = g_q ? m1_wr_rs      : m0_wr_rs;
        sel_ma     = g_q ? m1_ma         : m0_ma;
        sel_mb     = g_q ? m1_mb_out     : m0_mb_out;
    end

    // Arbitration and cycle-tracking next state.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        last_d   = last_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        pick     = 1'b0;
        nxm_c    = 1'b0;
        timer_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m0_rq_cyc || m1_rq_cyc) begin
                    if (m0_rq_cyc && m1_rq_cyc) begin
                        pick = (FIXED_PRIO != 0) ? 1'b0 : !last_q;
                    end else begin
                        pick = m1_rq_cyc;
                    end
                    g_d     = pick;
                    last_d  = pick;
                    rd_d    = pick ? m1_rd_rq : m0_rd_rq;
                    wr_d    = pick ? m1_wr_rq : m0_wr_rq;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!sel_rq_cyc) begin
                    state_d = ST_IDLE;
                end else if (mem_addr_ack) begin
                    state_d = ST_DATA;
                end else if (timer_exp_c) begin
                    nxm_c   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_DATA: begin
                // Writes (incl. read-modify-write) end on wr_rs, reads on rd_rs.
                if (wr_q ? sel_wr_rs : mem_rd_rs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign timer_clr = (state_d != ST_ADDR);

    membus_arb2_nxm_timer #(
        .LIMIT (NXM_TIMEOUT),
        .W     (TW)
    ) u_nxm_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clr),
        .enable   (timer_en),
        .expire_c (timer_exp_c)
    );

    // State and grant registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            g_q     <= 1'b0;
            last_q  <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Outputs are quiet in IDLE and while reset is asserted.
    assign live = !reset && (state_q != ST_IDLE);

    assign mem_rq_cyc     = live && sel_rq_cyc;
    assign mem_rd_rq      = live && sel_rd_rq;
    assign mem_wr_rq      = live && sel_wr_rq;
    assign mem_fmc_select = live && sel_fmc;
    assign mem_wr_rs      = live && sel_wr_rs;
    assign mem_ma         = live ? sel_ma : '0;
    assign mem_mb_out     = live ? sel_mb : '0;

    assign m0_addr_ack = live && !g_q && (state_q == ST_ADDR) && mem_addr_ack;
    assign m1_addr_ack = live &&  g_q && (state_q == ST_ADDR) && mem_addr_ack;
    assign m0_rd_rs    = live && !g_q && (state_q == ST_DATA) && mem_rd_rs;
    assign m1_rd_rs    = live &&  g_q && (state_q == ST_DATA) && mem_rd_rs;
    assign m0_mb_in    = (live && !g_q) ? mem_mb_in : '0;
    assign m1_mb_in    = (live &&  g_q) ? mem_mb_in : '0;
    assign m0_nxm      = !reset && !g_q && nxm_c;
    assign m1_nxm      = !reset &&  g_q && nxm_c;

endmodule
